// File: rtl/arm_pkg.sv
// Shared arm definitions: source-select state encodings, axis width and the
// neutral axis position used after reset and clear.
package arm_pkg;

  localparam int AXIS_W     = 8;
  localparam int CENTER_POS = 50;

  // State encodings shared with the arm source-select FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REC  = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

endpackage

// File: rtl/pose_recorder_if.sv
// Control, live-accelerometer and playback signals of the pose recorder.
interface pose_recorder_if
  import arm_pkg::*;
#(
  parameter int DATA_W = AXIS_W,
  parameter int ADDR_W = 6
);
  logic              rec_pulse;
  logic              play_pulse;
  logic              stop_pulse;
  logic              loop_en;
  logic [DATA_W-1:0] data_accel_x;
  logic [DATA_W-1:0] data_accel_y;
  logic [DATA_W-1:0] data_accel_z;
  logic [DATA_W-1:0] data_mem_x;
  logic [DATA_W-1:0] data_mem_y;
  logic [DATA_W-1:0] data_mem_z;
  logic              mem_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic [1:0]        state;

  modport master (
    output rec_pulse, play_pulse, stop_pulse, loop_en,
    output data_accel_x, data_accel_y, data_accel_z,
    input  data_mem_x, data_mem_y, data_mem_z,
    input  mem_valid, count, full, state
  );

  modport slave (
    input  rec_pulse, play_pulse, stop_pulse, loop_en,
    input  data_accel_x, data_accel_y, data_accel_z,
    output data_mem_x, data_mem_y, data_mem_z,
    output mem_valid, count, full, state
  );
endinterface

// File: rtl/pose_ram.sv
// Pose triplet memory: one write port, registered read port (block RAM style).
module pose_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write and registered read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pose_recorder.sv
// Records accelerometer pose triplets at the sample tick rate and plays them
// back, once or looped, as the data_mem_* stream for the arm source selector.
module pose_recorder
  import arm_pkg::*;
#(
  parameter int DATA_W     = AXIS_W,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int SAMPLE_DIV = 500000,
  parameter int CENTER     = CENTER_POS
) (
  input logic            clk,
  input logic            rst,
  pose_recorder_if.slave bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = ADDR_W + 1;
  localparam int POSE_W = 3 * DATA_W;

  logic [1:0]        state_r, state_nxt;
  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic              we;
  logic              last_rd;
  logic              play_hold;
  logic [POSE_W-1:0] pose_p1;
  logic [DATA_W-1:0] x_p2, y_p2, z_p2;
  logic              vld_p2;

  assign tick    = (state_r != ST_IDLE) && (div == DIV_W'(SAMPLE_DIV - 1));
  assign last_rd = ({1'b0, rd_ptr} == count_r - CNT_W'(1));
  assign we      = (state_r == ST_REC) && tick && !bus.stop_pulse;
  // Playback output only updates while PLAY continues; on exit it holds
  assign play_hold = (state_r == ST_PLAY) && (state_nxt == ST_PLAY);

  // Next state and next read pointer; stop always beats a coincident tick
  always_comb begin
    state_nxt  = state_r;
    rd_ptr_nxt = rd_ptr;
    case (state_r)
      ST_IDLE: begin
        if (bus.rec_pulse) begin
          state_nxt = ST_REC;
        end else if (bus.play_pulse && (count_r != '0)) begin
          state_nxt  = ST_PLAY;
          rd_ptr_nxt = '0;
        end
      end
      ST_REC: begin
        if (bus.stop_pulse) state_nxt = ST_IDLE;
        else if (tick && (count_r == CNT_W'(DEPTH - 1))) state_nxt = ST_IDLE;
      end
      ST_PLAY: begin
        if (bus.stop_pulse) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if (!last_rd)        rd_ptr_nxt = rd_ptr + ADDR_W'(1);
          else if (bus.loop_en) rd_ptr_nxt = '0;
          else                 state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read address runs one step ahead so the registered read lines up with rd_ptr
  pose_ram #(
    .DATA_W(POSE_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata({bus.data_accel_x, bus.data_accel_y, bus.data_accel_z}),
    .raddr(rd_ptr_nxt),
    .rdata(pose_p1)
  );

  // FSM, divider, pointers, count and the playback output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      div     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      vld_p2  <= 1'b0;
      x_p2    <= DATA_W'(CENTER);
      y_p2    <= DATA_W'(CENTER);
      z_p2    <= DATA_W'(CENTER);
    end else begin
      state_r <= state_nxt;
      rd_ptr  <= rd_ptr_nxt;
      if ((state_r == ST_IDLE) || (state_nxt != state_r) || tick) div <= '0;
      else div <= div + DIV_W'(1);
      if ((state_r == ST_IDLE) && bus.rec_pulse) begin
        count_r <= '0;
        wr_ptr  <= '0;
        full_r  <= 1'b0;
      end else if (we) begin
        wr_ptr  <= wr_ptr + ADDR_W'(1);
        count_r <= count_r + CNT_W'(1);
        if (count_r == CNT_W'(DEPTH - 1)) full_r <= 1'b1;
      end
      // ---- stage p2: registered RAM word presented as playback sample ----
      vld_p2 <= play_hold;
      if (play_hold) begin
        x_p2 <= pose_p1[3*DATA_W-1:2*DATA_W];
        y_p2 <= pose_p1[2*DATA_W-1:DATA_W];
        z_p2 <= pose_p1[DATA_W-1:0];
      end
    end
  end

  assign bus.data_mem_x = x_p2;
  assign bus.data_mem_y = y_p2;
  assign bus.data_mem_z = z_p2;
  assign bus.mem_valid  = vld_p2;
  assign bus.count      = count_r;
  assign bus.full       = full_r;
  assign bus.state      = state_r;

endmodule

// File: doc/pose_recorder.md
Name: pose_recorder

Overview:
- Records accelerometer pose triplets (x, y, z) into an internal sample memory and plays them back at a fixed sample rate.
- Produces the data_mem_x/y/z stream that the arm's source-select state machine consumes in its MEM mode.
- Sits between the accelerometer interface and the arm source selector.
- Recording is the write side; playback is the read side of the same pose memory.

Parameters:
- DATA_W, 8, width of each axis sample.
- DEPTH, 64, number of pose triplets stored.
- ADDR_W, 6, address width (equals log2 DEPTH).
- SAMPLE_DIV, 500000, clocks per sample tick (10 ms at 50 MHz); minimum 2.
- CENTER, 50, axis value driven after reset and after clear.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rec_pulse  in  1  one-cycle pulse, already debounced: start recording.
- play_pulse  in  1  one-cycle pulse: start playback.
- stop_pulse  in  1  one-cycle pulse: end recording or playback.
- loop_en  in  1  level: repeat playback continuously.
- data_accel_x/y/z  in  DATA_W each  live accelerometer axes.
- data_mem_x/y/z  out  DATA_W each  playback axes.
- mem_valid  out  1  high while data_mem_* holds a played-back sample.
- count  out  ADDR_W+1  number of stored triplets.
- full  out  1  count == DEPTH.
- state  out  2  IDLE=0, REC=1, PLAY=2.

Behaviour:
- Reset (rst high at a clk edge), values visible the next cycle:
  - state=IDLE; count=0; full=0; mem_valid=0.
  - data_mem_x/y/z=CENTER; write and read pointers=0; divider=0.
  - Memory contents are not cleared; count alone defines valid data.
- Divider: counts 0..SAMPLE_DIV-1 only in REC or PLAY. tick is high on the cycle the divider equals SAMPLE_DIV-1. The divider restarts at 0 on every state entry.
- IDLE:
  - rec_pulse -> REC next cycle; count=0, wr_ptr=0, full=0.
  - play_pulse with count>0 -> PLAY next cycle; rd_ptr=0.
  - play_pulse with count==0 is ignored.
  - rec_pulse and play_pulse together: rec wins.
  - data_mem_* holds its last value; mem_valid=0.
- REC:
  - On tick: write {accel x,y,z} sampled on that cycle at wr_ptr; wr_ptr+1; count+1.
  - When the write makes count==DEPTH: full=1 and state=IDLE next cycle, with no wrap and no overwrite.
  - stop_pulse -> IDLE next cycle. If stop_pulse and tick coincide, stop wins and no write occurs.
  - rec_pulse and play_pulse are ignored.
- PLAY:
  - Memory read is registered. data_mem_* = mem[rd_ptr] and mem_valid=1 one cycle after rd_ptr is set. With a play_pulse at cycle N, entry 0 appears at N+2.
  - On tick: if rd_ptr < count-1, increment rd_ptr.
  - On tick with rd_ptr == count-1: if loop_en, rd_ptr=0; otherwise go to IDLE next cycle, and data_mem_* holds the last sample.
  - stop_pulse -> IDLE next cycle; it wins over a coincident tick.
  - rec_pulse and play_pulse are ignored.
- Count is preserved across playbacks. A new recording discards it (count=0 on REC entry).
- Reset mid-REC or mid-PLAY: same as the reset rule; the partial recording is lost.
- No arithmetic saturation is needed: the pointers never exceed DEPTH-1 by construction.

Decomposition:
- Shared package arm_pkg holds:
  - state encodings ST_IDLE/ST_REC/ST_PLAY, shared with the source-select FSM.
  - CENTER_POS=50.
  - the axis width constant.
- Sub-module pose_ram: single-port-write / registered-read array, DEPTH x (3*DATA_W), inferred as block RAM. Ports: clk, we, waddr, wdata, raddr, rdata.
- The FSM, divider and pointers stay in pose_recorder.

Test Plan:
All scenarios use SAMPLE_DIV=4 and DEPTH=8.
- Reset check: hold rst 2 cycles -> data_mem_*=50, state=0, count=0, mem_valid=0, full=0.
- Record: rec_pulse, accel x/y/z=10/20/30 then 11/21/31 on successive ticks, stop_pulse after 3 ticks -> count=3, state back to 0.
- Playback: play_pulse with loop_en=0 -> data_mem = 10/20/30 at N+2, next triplet every 4 clocks, returns to IDLE after 3 samples, data_mem holds the third triplet, mem_valid falls.
- Fill to full: record 9+ ticks -> count=8, full=1, auto-return to IDLE after the 8th write, no 9th write.
- Loop with stop: loop_en=1 -> sequence wraps from entry 7 to entry 0. stop_pulse coincident with tick -> IDLE, rd_ptr not advanced.
- Corner pulses:
  - play_pulse with count=0 -> stays IDLE.
  - rec_pulse+play_pulse together -> REC.
  - rst mid-PLAY -> full reset values.
